// File: rtl/accumulator_bank.sv
// accumulator_bank: NUM_ACC accumulators with per-cycle ops, a carry flag
// and a shared LIFO context stack for save/restore.
module accumulator_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_ACC     = 4,
  parameter int SEL_W       = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      acc_sel,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] ac_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  carry,
  output logic                  zero,
  output logic                  neg,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] acc_q [NUM_ACC];
  logic [DATA_WIDTH-1:0] acc_d [NUM_ACC];
  logic [DATA_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] stk_d [STACK_DEPTH];
  logic [SP_W-1:0]       sp_q, sp_d;
  logic                  carry_q, carry_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] a, op_val;
  logic                  push_ok, pop_ok, bad;
  logic [IX_W-1:0]       wr_ix, rd_ix;
  assign a           = acc_q[acc_sel];
  assign ac_out      = a;
  assign zero        = ~|a;
  assign neg         = a[DATA_WIDTH-1];
  assign carry       = carry_q;
  assign stack_err   = err_q;
  assign stack_empty = sp_q == '0;
  assign stack_full  = sp_q == SP_W'(STACK_DEPTH);
  assign wr_ix       = IX_W'(sp_q);
  assign rd_ix       = IX_W'(sp_q - SP_W'(1));
  assign push_ok     = push & ~pop & ~stack_full;
  assign pop_ok      = pop & ~push & ~stack_empty;
  assign bad         = (push & pop) | (push & stack_full) | (pop & stack_empty);
  always_comb begin
    op_val = op == 3'd1 ? ac_in :
             op == 3'd2 ? '0 :
             op == 3'd3 ? a + DATA_WIDTH'(1) :
             op == 3'd4 ? a - DATA_WIDTH'(1) :
             op == 3'd5 ? {a[DATA_WIDTH-2:0], 1'b0} :
             op == 3'd6 ? {1'b0, a[DATA_WIDTH-1:1]} : a;
    carry_d = (op == 3'd1 || op == 3'd2) ? 1'b0 :
              op == 3'd3 ? &a :
              op == 3'd4 ? ~|a :
              op == 3'd5 ? a[DATA_WIDTH-1] :
              op == 3'd6 ? a[0] : carry_q;
    acc_d = acc_q;
    acc_d[acc_sel] = pop_ok ? stk_q[rd_ix] : op_val;
    stk_d = stk_q;
    if (push_ok) stk_d[wr_ix] = a;
    sp_d  = push_ok ? sp_q + SP_W'(1) : pop_ok ? sp_q - SP_W'(1) : sp_q;
    err_d = bad | (err_q & ~clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '{default: '0};
      stk_q   <= '{default: '0};
      sp_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      stk_q   <= stk_d;
      sp_q    <= sp_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end
endmodule
